// File: rtl/gray_conv_seq.sv
// gray_conv_seq: bit-serial Gray/binary code converter.
//   Captures an operand on start and produces one result bit per clock,
//   MSB first. The finished word appears on dout together with a
//   one-cycle done pulse.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   start  - conversion request, sampled when not busy
//   mode   - 0: Gray-to-binary, 1: binary-to-Gray (sampled with start)
//   din    - operand word (sampled with start)
//   busy   - high while a conversion is in progress
//   done   - one-cycle pulse, new result present on dout
//   dout   - result word, held between conversions
module gray_conv_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             prev_q, prev_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept_c;
    logic [WIDTH-1:0] op_shr_c;
    logic             upper_c;
    logic             bit_c;

    // A new operand is taken in any state except CONV (covers back-to-back from DONE).
    assign accept_c = start && (state_q != CONV);

    // Current result bit. The left neighbour comes from the operand for
    // binary-to-Gray, or from the previously computed bit for Gray-to-binary.
    // The shifted operand and the cleared prev bit both yield 0 at the MSB.
    assign op_shr_c = {1'b0, op_q[WIDTH-1:1]};
    assign upper_c  = mode_q ? op_shr_c[idx_q] : prev_q;
    assign bit_c    = op_q[idx_q] ^ upper_c;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                // Finish on index 0 itself; the index never steps below 0.
                if (idx_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? CONV : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        op_d   = op_q;
        mode_d = mode_q;
        idx_d  = idx_q;
        res_d  = res_q;
        prev_d = prev_q;
        dout_d = dout_q;
        busy_d = (state_d == CONV);
        done_d = (state_d == DONE);

        if (accept_c) begin
            op_d   = din;
            mode_d = mode;
            idx_d  = IDX_TOP;
            res_d  = '0;
            prev_d = 1'b0;
        end else if (state_q == CONV) begin
            res_d[idx_q] = bit_c;
            prev_d       = bit_c;
            if (idx_q != '0) begin
                idx_d = idx_q - IDX_ONE;
            end else begin
                // Publish only the completed word; partial results stay internal.
                dout_d = res_d;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            mode_q <= 1'b0;
            idx_q  <= '0;
            res_q  <= '0;
            prev_q <= 1'b0;
            dout_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            mode_q <= mode_d;
            idx_q  <= idx_d;
            res_q  <= res_d;
            prev_q <= prev_d;
            dout_q <= dout_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_gray_conv_seq.sv
// Scoreboard bench for gray_conv_seq: a WIDTH=4 and a WIDTH=8 instance,
// random and directed conversions against an arithmetic reference model.
module tb_gray_conv_seq;

    typedef struct {
        logic [15:0] val;
        int unsigned due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start4, mode4, busy4, done4;
    logic [3:0] din4, dout4;
    logic       start8, mode8, busy8, done8;
    logic [7:0] din8, dout8;

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        q4[$];
    exp_t        q8[$];
    logic [15:0] last4 = '0;
    logic [15:0] last8 = '0;

    gray_conv_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode4), .din(din4),
        .busy(busy4), .done(done4), .dout(dout4)
    );

    gray_conv_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode8), .din(din8),
        .busy(busy8), .done(done8), .dout(dout8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mask_w(input int w);
        return 16'((32'd1 << w) - 1);
    endfunction

    function automatic logic [15:0] b2g(input logic [15:0] x, input int w);
        return (x ^ (x >> 1)) & mask_w(w);
    endfunction

    // Binary value is the XOR of all right-shifts of the Gray word.
    function automatic logic [15:0] g2b(input logic [15:0] x, input int w);
        logic [15:0] r = '0;
        for (int k = 0; k < w; k++) r = r ^ (x >> k);
        return r & mask_w(w);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic m, input logic [15:0] d);
        if (w == 4) begin
            start4 = s; mode4 = m; din4 = d[3:0];
        end else begin
            start8 = s; mode8 = m; din8 = d[7:0];
        end
    endtask

    task automatic idle(input int w, input int n);
        repeat (n) begin
            @(negedge clk);
            drive(w, 1'b0, 1'b0, 16'h0);
        end
    endtask

    // One conversion: gap idle cycles, a start pulse, then w cycles during
    // which the inputs are either quiet or randomly scrambled.
    task automatic run(input int w, input logic m, input logic [15:0] d_in,
                       input bit noise, input int gap);
        exp_t        e;
        logic [15:0] d;
        d = d_in & mask_w(w);
        idle(w, gap);
        @(negedge clk);
        drive(w, 1'b1, m, d);
        e.val = m ? b2g(d, w) : g2b(d, w);
        e.due = cyc + 1 + w;
        if (w == 4) q4.push_back(e); else q8.push_back(e);
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            if (noise) drive(w, 1'($urandom), 1'($urandom), 16'($urandom));
            else       drive(w, 1'b0, m, d);
        end
    endtask

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin : mon4
        logic exp_busy, exp_done;
        while (q4.size() > 0 && q4[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL done4_missing: no done seen by cycle %0d expected %h", q4[0].due, q4[0].val);
            void'(q4.pop_front());
        end
        exp_busy = 1'b0;
        foreach (q4[k]) if (cyc + 4 >= q4[k].due && cyc < q4[k].due) exp_busy = 1'b1;
        exp_done = (q4.size() > 0) && (q4[0].due == cyc);
        check("busy4", 16'(busy4), 16'(exp_busy));
        check("done4", 16'(done4), 16'(exp_done));
        if (exp_done) begin
            last4 = q4[0].val;
            void'(q4.pop_front());
        end
        check("dout4", 16'(dout4), last4);
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin : mon8
        logic exp_busy, exp_done;
        while (q8.size() > 0 && q8[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL done8_missing: no done seen by cycle %0d expected %h", q8[0].due, q8[0].val);
            void'(q8.pop_front());
        end
        exp_busy = 1'b0;
        foreach (q8[k]) if (cyc + 8 >= q8[k].due && cyc < q8[k].due) exp_busy = 1'b1;
        exp_done = (q8.size() > 0) && (q8[0].due == cyc);
        check("busy8", 16'(busy8), 16'(exp_busy));
        check("done8", 16'(done8), 16'(exp_done));
        if (exp_done) begin
            last8 = q8[0].val;
            void'(q8.pop_front());
        end
        check("dout8", 16'(dout8), last8);
    end

    // Start a 4-bit conversion, then hit reset asynchronously while bit 2 is in progress.
    task automatic reset_mid_conv4();
        exp_t e;
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 16'hB);
        e.val = g2b(16'hB, 4);
        e.due = cyc + 1 + 4;
        q4.push_back(e);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        q4.delete();
        q8.delete();
        last4 = '0;
        last8 = '0;
        #1;
        check("rst_busy4", 16'(busy4), 16'h0);
        check("rst_done4", 16'(done4), 16'h0);
        check("rst_dout4", 16'(dout4), 16'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        drive(4, 1'b0, 1'b0, 16'h0);
        drive(8, 1'b0, 1'b0, 16'h0);
        #1;
        reset = 1'b1;
        #1;
        check("init_busy4", 16'(busy4), 16'h0);
        check("init_done4", 16'(done4), 16'h0);
        check("init_dout4", 16'(dout4), 16'h0);
        check("init_dout8", 16'(dout8), 16'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // Directed: Gray 1101 -> binary 1001, then binary 1001 -> Gray 1101.
        run(4, 1'b0, 16'hD, 1'b0, 1);
        run(4, 1'b1, 16'h9, 1'b0, 1);
        // Inputs scrambled throughout CONV must not disturb the captured operand.
        run(4, 1'b0, 16'h6, 1'b1, 1);
        idle(4, 3);

        reset_mid_conv4();
        // First start after reset is accepted normally.
        run(4, 1'b1, 16'h3, 1'b0, 1);

        // Exhaustive round trip, all back-to-back.
        for (int x = 0; x < 16; x++) begin
            run(4, 1'b1, 16'(x), 1'b0, 0);
            run(4, 1'b0, b2g(16'(x), 4), 1'b0, 0);
        end

        for (int n = 0; n < 40; n++) begin
            run(4, 1'($urandom), 16'($urandom), bit'($urandom % 2), int'($urandom_range(0, 2)));
        end
        idle(4, 3);

        // 8-bit: FF -> AA, then back-to-back AA -> FF.
        run(8, 1'b0, 16'hFF, 1'b0, 1);
        run(8, 1'b1, 16'hAA, 1'b0, 0);
        for (int n = 0; n < 10; n++) begin
            run(8, 1'($urandom), 16'($urandom), bit'($urandom % 2), int'($urandom_range(0, 1)));
        end
        idle(8, 3);

        for (int t = 0; t < 50 && (q4.size() > 0 || q8.size() > 0); t++) @(negedge clk);
        if (q4.size() > 0 || q8.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d/%0d results still pending", q4.size(), q8.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
